// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Fetch, issue and next-PC bundle between the program-counter
//                sequencer and the rest of the RV32I core.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_sequencer_if;
    // Instruction-memory fetch handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // Issue to decoder / datapath
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    // Next-PC resolution
    logic        NextPCSrc;
    logic [31:0] branch_target;
    // Status
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;
    logic [31:0] instret;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, instr, instr_valid,
               pc, pc_plus4, trap, instret,
        input  imem_ack, imem_rdata, exec_done, NextPCSrc, branch_target
    );

    // Memory / datapath side
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
               pc, pc_plus4, trap, instret,
        output imem_ack, imem_rdata, exec_done, NextPCSrc, branch_target
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : RV32I program-counter sequencer. Fetches one instruction at a
//                time, issues it, waits for exec_done, then resolves the next
//                PC (sequential, taken target, or trap on misaligned target).
//                Counts retired instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pc_sequencer_if.master  bus
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    logic        first_q;     // set only in the first EXEC cycle of an instruction

    logic [31:0] pc_plus4_w;
    logic        resolve_w;
    logic        misalign_w;
    logic [31:0] pc_d;
    logic [31:0] instret_d;

    assign pc_plus4_w = pc_q + 32'd4;
    assign resolve_w  = (state_q == S_EXEC) && bus.exec_done;
    assign misalign_w = bus.NextPCSrc && (bus.branch_target[1:0] != 2'b00);

    // Next PC and retire count, only consumed in a resolving EXEC cycle
    always_comb begin
        pc_d      = pc_plus4_w;
        instret_d = instret_q + 32'd1;
        if (bus.NextPCSrc) begin
            if (misalign_w) begin
                pc_d      = TRAP_VEC;
                instret_d = instret_q;
            end else begin
                pc_d      = bus.branch_target;
            end
        end
    end

    // Fetch / execute sequencing and architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VEC;
            instr_q   <= 32'd0;
            instret_q <= 32'd0;
            first_q   <= 1'b0;
        end else if (state_q == S_FETCH) begin
            first_q <= 1'b0;
            if (bus.imem_ack) begin
                instr_q <= bus.imem_rdata;
                first_q <= 1'b1;
                state_q <= S_EXEC;
            end
        end else begin
            first_q <= 1'b0;
            if (bus.exec_done) begin
                pc_q      <= pc_d;
                instret_q <= instret_d;
                state_q   <= S_FETCH;
            end
        end
    end

    // Strobes are masked by rst so nothing leaks out during a reset cycle;
    // imem_req must already be high in the first cycle after rst falls.
    assign bus.imem_req    = !rst && (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = !rst && first_q && (state_q == S_EXEC);
    assign bus.trap        = !rst && resolve_w && misalign_w;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4_w;
    assign bus.instret     = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer: directed vector table,
//                reset-mid-EXEC sequence and randomized instruction stream
//                compared against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] C_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VEC  = 32'h0000_0100;

    logic clk;
    logic rst;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VEC (C_RESET_VEC),
        .TRAP_VEC  (C_TRAP_VEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural PC and retire count
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    typedef struct {
        int          w;       // cycles imem_ack is withheld
        int          e;       // cycles exec_done is withheld
        logic [31:0] data;
        logic        nsrc;
        logic [31:0] tgt;
        logic [31:0] exp_pc;  // PC after the instruction resolves
        logic [31:0] exp_ret; // instret after the instruction resolves
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full instruction: fetch with w wait cycles, execute with e wait cycles.
    task automatic run_instr(input int w, input int e, input logic [31:0] data,
                             input logic nsrc, input logic [31:0] tgt);
        int          vld;
        logic        exp_trap;
        vld      = 0;
        exp_trap = nsrc && (tgt[1:0] != 2'b00);
        for (int i = 0; i <= w; i++) begin
            bus.imem_ack      = (i == w);
            bus.imem_rdata    = (i == w) ? data : $urandom;
            bus.exec_done     = 1'($urandom);     // must be ignored in FETCH
            bus.NextPCSrc     = 1'($urandom);
            bus.branch_target = $urandom;
            @(negedge clk);
            chk("fetch_req",   {31'd0, bus.imem_req}, 32'd1);
            chk("fetch_addr",  bus.imem_addr, m_pc);
            chk("fetch_trap",  {31'd0, bus.trap}, 32'd0);
            vld += int'(bus.instr_valid);
            @(posedge clk); #1;
        end
        for (int j = 0; j <= e; j++) begin
            bus.imem_ack      = 1'($urandom);     // must be ignored in EXEC
            bus.imem_rdata    = $urandom;
            bus.exec_done     = (j == e);
            bus.NextPCSrc     = (j == e) ? nsrc : 1'($urandom);
            bus.branch_target = (j == e) ? tgt  : $urandom;
            @(negedge clk);
            chk("exec_req",   {31'd0, bus.imem_req}, 32'd0);
            chk("exec_instr", bus.instr, data);
            chk("exec_pc",    bus.pc, m_pc);
            chk("exec_pc4",   bus.pc_plus4, m_pc + 32'd4);
            chk("exec_trap",  {31'd0, bus.trap}, {31'd0, (j == e) && exp_trap});
            chk("exec_ret",   bus.instret, m_ret);
            vld += int'(bus.instr_valid);
            @(posedge clk); #1;
        end
        chk("valid_pulses", vld, 1);
        // Reference model update from the architectural rules
        if (!nsrc) begin
            m_pc  = m_pc + 32'd4;
            m_ret = m_ret + 32'd1;
        end else if (tgt % 4 == 0) begin
            m_pc  = tgt;
            m_ret = m_ret + 32'd1;
        end else begin
            m_pc  = C_TRAP_VEC;
        end
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        // Next cycle must already be a fetch of the resolved PC
        chk("post_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("post_addr", bus.imem_addr, m_pc);
        chk("post_ret",  bus.instret, m_ret);
    endtask

    initial begin
        tbl[0] = '{0, 0, 32'h0000_0013, 1'b0, 32'h0,         32'h0000_0004, 32'd1};
        tbl[1] = '{0, 0, 32'h0010_0093, 1'b0, 32'h0,         32'h0000_0008, 32'd2};
        tbl[2] = '{0, 0, 32'h0000_0063, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'd3};
        tbl[3] = '{0, 0, 32'h0020_0113, 1'b0, 32'h0,         32'h0000_0044, 32'd4};
        tbl[4] = '{0, 0, 32'h0000_006F, 1'b1, 32'h0000_0042, 32'h0000_0100, 32'd4};
        tbl[5] = '{3, 2, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'h0000_0104, 32'd5};
        tbl[6] = '{1, 1, 32'h1234_5678, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd6};
        tbl[7] = '{0, 1, 32'h0BAD_F00D, 1'b0, 32'h0,         32'h0000_0000, 32'd7};

        rst               = 1'b1;
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = 32'd0;
        bus.exec_done     = 1'b0;
        bus.NextPCSrc     = 1'b0;
        bus.branch_target = 32'd0;

        // Reset held for two edges; strobes low while rst is high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_trap",  {31'd0, bus.trap},        32'd0);
        rst = 1'b0;
        #1;
        chk("rel_pc",    bus.pc,        C_RESET_VEC);
        chk("rel_ret",   bus.instret,   32'd0);
        chk("rel_instr", bus.instr,     32'd0);
        chk("rel_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rel_req",   {31'd0, bus.imem_req},    32'd1);
        chk("rel_addr",  bus.imem_addr, C_RESET_VEC);
        m_pc  = C_RESET_VEC;
        m_ret = 32'd0;

        // Directed vector table
        for (int k = 0; k < 8; k++) begin
            run_instr(tbl[k].w, tbl[k].e, tbl[k].data, tbl[k].nsrc, tbl[k].tgt);
            chk($sformatf("tbl%0d_pc", k),  bus.pc,      tbl[k].exp_pc);
            chk($sformatf("tbl%0d_ret", k), bus.instret, tbl[k].exp_ret);
        end

        // Reset while an instruction is waiting in EXEC
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
        bus.exec_done  = 1'b0;
        @(posedge clk); #1;
        rst               = 1'b1;
        bus.exec_done     = 1'b1;
        bus.NextPCSrc     = 1'b1;
        bus.branch_target = 32'h0000_0042;
        @(negedge clk);
        chk("mid_rst_trap",  {31'd0, bus.trap},        32'd0);
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_rst_req",   {31'd0, bus.imem_req},    32'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.exec_done = 1'b0;
        bus.NextPCSrc = 1'b0;
        #1;
        chk("mid_rst_pc",   bus.pc,        C_RESET_VEC);
        chk("mid_rst_ret",  bus.instret,   32'd0);
        chk("mid_rst_req1", {31'd0, bus.imem_req}, 32'd1);
        chk("mid_rst_addr", bus.imem_addr, C_RESET_VEC);
        m_pc  = C_RESET_VEC;
        m_ret = 32'd0;

        // Randomized instruction stream against the reference model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] t;
            logic        ns;
            ns = 1'($urandom);
            t  = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $urandom, ns, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
